// File: rtl/key_arbiter_ctrl.sv
// Two-requester round-robin arbiter feeding one shared key/trigger core, with a WAIT timeout.
// Optional trigger-sequence monitor enabled by defining TROJAN_MON_EN.
module key_arbiter_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [55:0] req0_key,
  input  logic [31:0] req0_trigger,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [55:0] req1_key,
  input  logic [31:0] req1_trigger,
  output logic        req1_ready,
  output logic        core_valid,
  output logic [55:0] core_key,
  output logic [31:0] core_trigger,
  input  logic        core_ready,
  input  logic        core_done,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        err,
  output logic        alarm
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_LOCK  = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic [1:0]  grant_q, grant_d;
  logic [55:0] key_q, key_d;
  logic [31:0] trig_q, trig_d;
  logic        err_s;
  logic        sel_s;
  logic        accept_s;
  logic        lock_pend_s;
  logic [31:0] sel_trig_s;

  // Tie-break toward the requester not served last; otherwise take the only valid one.
  assign sel_s      = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  assign accept_s   = (state_q == S_IDLE) && !rst && (req0_valid || req1_valid);
  assign sel_trig_s = sel_s ? req1_trigger : req0_trigger;

  assign req0_ready   = accept_s && !sel_s;
  assign req1_ready   = accept_s && sel_s;
  assign core_valid   = (state_q == S_ISSUE);
  assign core_key     = key_q;
  assign core_trigger = trig_q;
  assign grant        = grant_q;
  assign busy         = (state_q != S_IDLE);
  assign err          = err_s;

`ifdef TROJAN_MON_EN
  logic [5:0] hist_q, hist_d;
  logic       alarm_q, alarm_d;

  // History of trigger[31:30] per accepted transfer, oldest in the top bits.
  always_comb begin
    hist_d  = hist_q;
    alarm_d = alarm_q;
    if (accept_s) begin
      hist_d = {hist_q[3:0], sel_trig_s[31:30]};
      if (hist_d == 6'b01_10_11) begin
        alarm_d = 1'b1;
      end else begin
        alarm_d = alarm_q;
      end
    end else begin
      hist_d = hist_q;
    end
  end

  // Monitor state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q  <= 6'd0;
      alarm_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      alarm_q <= alarm_d;
    end
  end

  assign lock_pend_s = alarm_q;
  assign alarm       = alarm_q;
`else
  logic unused_trig_s;
  assign unused_trig_s = ^sel_trig_s[31:30];
  assign lock_pend_s   = 1'b0;
  assign alarm         = 1'b0;
`endif

  // Next-state, capture and timeout logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    key_d   = key_q;
    trig_d  = trig_q;
    err_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          key_d   = sel_s ? req1_key : req0_key;
          trig_d  = sel_trig_s;
          grant_d = sel_s ? 2'b10 : 2'b01;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (core_ready) begin
          cnt_d   = 8'd0;
          state_d = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        // A done arriving on the final count beats the timeout.
        if (core_done || (cnt_q == CNT_LAST)) begin
          err_s   = !core_done;
          last_d  = grant_q[1];
          grant_d = 2'b00;
          cnt_d   = 8'd0;
          state_d = lock_pend_s ? S_LOCK : S_IDLE;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = S_WAIT;
        end
      end
      S_LOCK: begin
        state_d = S_LOCK;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      last_q  <= 1'b1;
      grant_q <= 2'b00;
      key_q   <= 56'd0;
      trig_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      key_q   <= key_d;
      trig_q  <= trig_d;
    end
  end

endmodule
